uart_tx_rr_scheduler: RTL and testbench
=======================================

// Module: uart_tx_rr_scheduler
// PURPOSE
// Shares one UART serial TX line between NUM_REQ on-chip requesters.
// - Round-robin arbitration per frame; valid/ready handshake on each requester port.
// - Serializes the granted word with its own baud counter: start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS.
// - Sits between producer blocks and the pad; on the bench, tx_o drives the rx of a uart_vip_if slave.
// PARAMETERS
// NUM_REQ      4            number of requesters, >=2
// DATA_WIDTH   8            data bits per frame, 5..9
// PARITY_TYPE  0            0 none, 1 odd, 2 even
// STOP_BITS    1            1 or 2
// CLK_FREQ_HZ  100_000_000  clk_i frequency
// BAUD_RATE    9600         bits/s; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide), must be >=2
// PORTS
// clk_i         in   1                   single clock
// rst_ni        in   1                   synchronous, active-low reset
// req_valid_i   in   NUM_REQ             requester i has a word
// req_data_i    in   NUM_REQ*DATA_WIDTH  word i at [i*DATA_WIDTH +: DATA_WIDTH]
// req_ready_o   out  NUM_REQ             one-hot accept; transfer when valid&ready
// tx_o          out  1                   serial line, idle high
// busy_o        out  1                   frame in progress (state != IDLE)
// grant_id_o    out  $clog2(NUM_REQ)     index of requester owning the current frame
// frame_done_o  out  1                   1-cycle pulse at end of last stop bit
// BEHAVIOUR
// - Reset, sampled on clk_i rising edge when rst_ni=0:
//   - outputs: tx_o=1, busy_o=0, req_ready_o=0, grant_id_o=0, frame_done_o=0.
//   - internal: state=IDLE, RR pointer=0, baud and bit counters=0.
//   - Reset mid-frame aborts the frame; tx_o=1 from the next edge; the aborted word is dropped.
// - FSM: IDLE -> START -> DATA -> [PARITY if PARITY_TYPE!=0] -> STOP -> IDLE.
// - IDLE:
//   - req_ready_o is combinational: one-hot to the first valid requester at or after the RR pointer, wrapping NUM_REQ-1 -> 0; 0 if none valid.
//   - On handshake: latch data, grant_id_o=winner, pointer=winner+1 (mod NUM_REQ), next state START.
//   - Arbitration and acceptance take the same cycle.
// - Bit timing:
//   - Each bit holds tx_o for exactly CLKS_PER_BIT cycles; the baud counter clears at every bit boundary.
//   - START bit: tx_o=0.
//   - DATA: bit k = latched[k], k=0..DATA_WIDTH-1.
//   - PARITY: odd -> ~^data, even -> ^data.
//   - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
// - Latency:
//   - tx_o falls on the edge after the handshake.
//   - Frame length = CLKS_PER_BIT*(1+DATA_WIDTH+(PARITY_TYPE!=0)+STOP_BITS) cycles.
// - frame_done_o pulses in the final STOP cycle; the next cycle is IDLE with tx_o=1.
// - Back-to-back: frames are separated by exactly 1 idle cycle (the arbitration cycle).
// - Requests:
//   - req_valid_i may drop before grant without effect.
//   - req_ready_o=0 in all non-IDLE states; req_data_i is ignored after acceptance.
// - Simultaneous valids: the pointer decides; a requester holding valid waits at most NUM_REQ-1 frames.
// STRUCTURE
// - Package uart_sched_pkg:
//   - parity_e {PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2}
//   - state_e {IDLE, START, DATA, PARITY, STOP}
//   - function clks_per_bit(clk_hz, baud)
// - Sub-module uart_rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + index, purely combinational.
// - Top holds the FSM, baud counter, bit counter, shift register and RR pointer register.
// TESTING (sim: CLK_FREQ_HZ=160_000, BAUD_RATE=10_000 -> CLKS_PER_BIT=16)
// - Single word: DATA_WIDTH=8, PARITY_TYPE=2, STOP_BITS=1, req0 sends 8'hA5.
//   -> tx_o: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
//   -> 176 cycles; frame_done_o once; uart_vip_if recv_data returns 8'hA5.
// - Round-robin: all four valid continuously, data 8'h10+i.
//   -> grant order 0,1,2,3,0.
//   -> exactly 1 idle cycle between frames; each VIP word matches.
// - Pointer wrap: after req3 is granted, req1 and req3 both valid.
//   -> req1 is granted first; req3 gets the next frame.
// - Odd parity with 2 stop bits: DATA_WIDTH=6, PARITY_TYPE=1, STOP_BITS=2, word 6'b111101.
//   -> parity bit 0; tx_o high for 32 stop cycles; frame length 160 cycles.
// - Reset mid-frame: rst_ni=0 for 1 cycle during DATA bit 3.
//   -> tx_o=1, busy_o=0 next edge; no frame_done_o.
//   -> after release, the next request starts cleanly with req0 granted first.
// - Ready protocol: req2 valid for 1 cycle while busy, then dropped.
//   -> req_ready_o stays 0; no frame issued for req2.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the round-robin UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module uart_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_rr_scheduler.sv
// Shares one UART TX line between NUM_REQ requesters; one frame per round-robin grant.
module uart_tx_rr_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY_TYPE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          frame_done_o
);
    localparam int unsigned CPB    = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BAUD_W = $clog2(CPB);
    localparam int unsigned BIT_W  = 4;
    localparam parity_e     PAR    = parity_e'(2'(PARITY_TYPE));
    localparam bit          HAS_PAR = (PAR != PAR_NONE);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_e                r_state, w_state_nxt;
    logic [BAUD_W-1:0]     r_baud, w_baud_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_par, w_par_nxt;
    logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]      r_gid, w_gid_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_par;
    logic                  w_bit_end;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Acceptance is only offered while idle and out of reset.
    assign w_ready = (r_state == IDLE && rst_ni) ? w_grant : '0;
    assign w_hs    = |(req_valid_i & w_ready);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) w_word = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_par     = (PAR == PAR_ODD) ? ~^w_word : ^w_word;
    assign w_bit_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + BAUD_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (w_hs) begin
                    w_state_nxt = START;
                    w_shift_nxt = w_word;
                    w_par_nxt   = w_par;
                    w_gid_nxt   = w_idx;
                    w_ptr_nxt   = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == DATA_LAST) begin
                        w_state_nxt = HAS_PAR ? PARITY : STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase

        // Registered outputs are decoded from the next-state values so they align with the state.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_par_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == STOP) && (w_bit_nxt == STOP_LAST) && (w_baud_nxt == BAUD_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign req_ready_o  = w_ready;
    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign grant_id_o   = r_gid;
    assign frame_done_o = r_done;

endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// Randomized + directed bench: frame-level reference model, serial-line monitor and scoreboard.
module tb_uart_tx_rr_scheduler;
    localparam int unsigned CLK_HZ = 160_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int          CPB    = 16;
    localparam int          NR     = 4;
    localparam int          DW     = 8;
    localparam int          FL1    = CPB * (1 + DW + 1 + 1);
    localparam int          DW2    = 6;
    localparam int          FL2    = CPB * (1 + DW2 + 1 + 2);

    typedef struct {
        logic [DW-1:0] data;
        bit            aborted;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n1 = 1'b0;
    logic [NR-1:0]    valid1 = '0;
    logic [NR*DW-1:0] data1  = '0;
    logic [NR-1:0]    ready1;
    logic             tx1, busy1, done1;
    logic [1:0]       gid1;

    logic              rst_n2 = 1'b0;
    logic [NR-1:0]     valid2 = '0;
    logic [NR*DW2-1:0] data2  = '0;
    logic [NR-1:0]     ready2;
    logic              tx2, busy2, done2;
    logic [1:0]        gid2;

    uart_tx_rr_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .PARITY_TYPE(2), .STOP_BITS(1),
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n1), .req_valid_i(valid1), .req_data_i(data1),
        .req_ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .grant_id_o(gid1), .frame_done_o(done1)
    );

    uart_tx_rr_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW2), .PARITY_TYPE(1), .STOP_BITS(2),
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)
    ) dut2 (
        .clk_i(clk), .rst_ni(rst_n2), .req_valid_i(valid2), .req_data_i(data2),
        .req_ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .grant_id_o(gid2), .frame_done_o(done2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state for dut: pending words per requester, RR pointer and the frame in flight.
    bit            pend[NR];
    logic [DW-1:0] pend_data[NR];
    logic          drv_rst_n = 1'b0;
    int            m_ptr = 0;
    int            m_busy_left = 0;
    logic [1:0]    m_gid = '0;
    logic [10:0]   m_bits = '1;
    exp_t          sb_q[$];
    int            obs_gid[$];
    bit            d2_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[2'((p + k) % NR)]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        int            w;
        int            pos;
        logic [DW-1:0] d;
        exp_t          e;
        if (m_busy_left > 0) begin
            pos = FL1 - m_busy_left;
            if (pos == 0) obs_gid.push_back(int'(gid1));
            chk("busy_in_frame", 32'(busy1), 32'(1));
            chk("ready_in_frame", 32'(ready1), 32'(0));
            chk("tx_bit", 32'(tx1), 32'(m_bits[4'(pos / CPB)]));
            chk("frame_done", 32'(done1), 32'(m_busy_left == 1));
            chk("grant_id", 32'(gid1), 32'(m_gid));
            m_busy_left--;
        end else begin
            w = rst_n1 ? rr_pick(valid1, m_ptr) : -1;
            chk("busy_idle", 32'(busy1), 32'(0));
            chk("tx_idle", 32'(tx1), 32'(1));
            chk("done_idle", 32'(done1), 32'(0));
            chk("grant_id_idle", 32'(gid1), 32'(m_gid));
            if (w >= 0) begin
                chk("ready_arb", 32'(ready1), 32'(1) << w);
                d = pend_data[w];
                e.data = d;
                e.aborted = 1'b0;
                sb_q.push_back(e);
                m_bits = {1'b1, ^d, d, 1'b0};
                m_gid = 2'(w);
                m_ptr = (w + 1) % NR;
                m_busy_left = FL1;
                pend[w] = 1'b0;
            end else begin
                chk("ready_none", 32'(ready1), 32'(0));
            end
        end
        if (!rst_n1) begin
            if (m_busy_left > 0) begin
                e = sb_q.pop_back();
                e.aborted = 1'b1;
                sb_q.push_back(e);
            end
            m_busy_left = 0;
            m_ptr = 0;
            m_gid = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rst_n1 = drv_rst_n;
        for (int i = 0; i < NR; i++) begin
            valid1[i] = pend[i];
            data1[i*DW +: DW] = pend_data[i];
        end
        #1;
        step();
    endtask

    task automatic clear_pend();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    endtask

    task automatic reset_dut();
        clear_pend();
        drv_rst_n = 1'b0;
        tick();
        drv_rst_n = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        for (int c = 0; c < 4 * FL1 && pend[i]; c++) tick();
    endtask

    task automatic drain(input int n);
        clear_pend();
        repeat (n) tick();
    endtask

    // Serial-line monitor: decodes frames mid-bit and checks them against the scoreboard.
    initial begin
        logic          prev;
        logic [DW-1:0] d;
        logic          st, p, sp;
        exp_t          e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx1) begin
                repeat (CPB / 2) @(negedge clk);
                st = tx1;
                for (int b = 0; b < DW; b++) begin
                    repeat (CPB) @(negedge clk);
                    d[b] = tx1;
                end
                repeat (CPB) @(negedge clk);
                p = tx1;
                repeat (CPB) @(negedge clk);
                sp = tx1;
                if (sb_q.size() == 0) begin
                    chk("sb_frame_expected", 32'(sb_q.size()), 32'(1));
                end else begin
                    e = sb_q.pop_front();
                    if (!e.aborted) begin
                        chk("mon_start", 32'(st), 32'(0));
                        chk("mon_data", 32'(d), 32'(e.data));
                        chk("mon_parity", 32'(p), 32'($countones(e.data) % 2));
                        chk("mon_stop", 32'(sp), 32'(1));
                    end
                end
            end
            prev = tx1;
        end
    end

    // Second configuration: 6 data bits, odd parity, two stop bits, checked cycle by cycle.
    initial begin
        logic [DW2-1:0] w2;
        logic [9:0]     b2;
        logic           par2;
        w2   = 6'b111101;
        par2 = ($countones(w2) % 2 == 0) ? 1'b1 : 1'b0;
        b2   = {2'b11, par2, w2, 1'b0};
        repeat (3) @(negedge clk);
        rst_n2 = 1'b1;
        @(negedge clk);
        #1;
        chk("d2_reset_tx", 32'(tx2), 32'(1));
        chk("d2_reset_busy", 32'(busy2), 32'(0));
        chk("d2_reset_ready", 32'(ready2), 32'(0));
        chk("d2_reset_gid", 32'(gid2), 32'(0));
        chk("d2_reset_done", 32'(done2), 32'(0));
        @(negedge clk);
        valid2 = 4'b1010;
        data2[1*DW2 +: DW2] = w2;
        data2[3*DW2 +: DW2] = 6'h2a;
        #1;
        chk("d2_ready_pick", 32'(ready2), 32'(4'b0010));
        @(negedge clk);
        valid2 = '0;
        #1;
        for (int c = 0; c < FL2; c++) begin
            chk("d2_tx_bit", 32'(tx2), 32'(b2[4'(c / CPB)]));
            chk("d2_busy", 32'(busy2), 32'(1));
            chk("d2_done", 32'(done2), 32'(c == FL2 - 1));
            chk("d2_gid", 32'(gid2), 32'(1));
            @(negedge clk);
            #1;
        end
        chk("d2_idle_busy", 32'(busy2), 32'(0));
        chk("d2_idle_tx", 32'(tx2), 32'(1));
        chk("d2_idle_done", 32'(done2), 32'(0));
        d2_done = 1'b1;
    end

    initial begin
        int exp_rr[5];
        int exp_wrap[3];
        exp_rr   = '{0, 1, 2, 3, 0};
        exp_wrap = '{3, 1, 3};
        clear_pend();
        for (int i = 0; i < NR; i++) pend_data[i] = '0;
        repeat (3) @(posedge clk);
        reset_dut();

        // Randomized traffic with random request arrival and withdrawal.
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 199) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b1;
                    pend_data[i] = 8'($urandom);
                end
            end
            tick();
        end
        drain(FL1 + 20);

        // Single word from req0.
        reset_dut();
        pend[0] = 1'b1;
        pend_data[0] = 8'hA5;
        wait_accept(0);
        drain(FL1 + 20);

        // All four requesters continuously valid.
        reset_dut();
        obs_gid.delete();
        for (int c = 0; c < 5 * (FL1 + 1); c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    pend[i] = 1'b1;
                    pend_data[i] = 8'(8'h10 + i);
                end
            end
            tick();
        end
        drain(FL1 + 20);
        chk("rr_frames", 32'(obs_gid.size()), 32'(5));
        for (int k = 0; k < 5 && k < obs_gid.size(); k++) chk("rr_order", 32'(obs_gid[k]), 32'(exp_rr[k]));

        // Pointer wrap: after req3, req1 beats req3.
        reset_dut();
        obs_gid.delete();
        pend[3] = 1'b1;
        pend_data[3] = 8'h3c;
        wait_accept(3);
        pend[1] = 1'b1;
        pend_data[1] = 8'h5a;
        pend[3] = 1'b1;
        pend_data[3] = 8'hc3;
        wait_accept(1);
        wait_accept(3);
        drain(FL1 + 20);
        chk("wrap_frames", 32'(obs_gid.size()), 32'(3));
        for (int k = 0; k < 3 && k < obs_gid.size(); k++) chk("wrap_order", 32'(obs_gid[k]), 32'(exp_wrap[k]));

        // Reset during data bit 3 drops the word and clears the pointer.
        reset_dut();
        pend[2] = 1'b1;
        pend_data[2] = 8'h96;
        wait_accept(2);
        while (m_busy_left > 0 && (FL1 - m_busy_left) < CPB + 3 * CPB + 4) tick();
        drv_rst_n = 1'b0;
        tick();
        drv_rst_n = 1'b1;
        drain(FL1 + 40);
        obs_gid.delete();
        pend[0] = 1'b1;
        pend_data[0] = 8'h01;
        pend[2] = 1'b1;
        pend_data[2] = 8'h02;
        wait_accept(0);
        wait_accept(2);
        drain(FL1 + 20);
        chk("post_reset_first", 32'(obs_gid.size() > 0 ? obs_gid[0] : -1), 32'(0));

        // Short-lived request while busy is never accepted.
        reset_dut();
        obs_gid.delete();
        pend[0] = 1'b1;
        pend_data[0] = 8'h77;
        wait_accept(0);
        repeat (20) tick();
        pend[2] = 1'b1;
        pend_data[2] = 8'hee;
        tick();
        pend[2] = 1'b0;
        drain(FL1 + 60);
        chk("ready_proto_frames", 32'(obs_gid.size()), 32'(1));

        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        for (int c = 0; c < 2000 && !d2_done; c++) @(negedge clk);
        chk("dut2_finished", 32'(d2_done), 32'(1));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
